melody_sequencer: RTL and testbench
===================================

// Module: melody_sequencer
// PURPOSE
//  Plays the 32-entry note table: steps note_index_o through 0..31 at a fixed tempo.
//  Reads the combinational divider value for each note, with one note per TEMPO_CYCLES.
//  Produces a square-wave tone_o whose half-period is divider_value_i clocks.
//  Sits between the notes ROM (index out, divider in) and the audio output pin.
//  Start and stop come from user inputs.
// PARAMETERS
//  BW           16         width of divider_value_i (half-period in clocks; 0 = rest)
//  TEMPO_CYCLES 1500000    clocks per note slot (PLAY + GAP); must be > GAP_CYCLES
//  GAP_CYCLES   150000     silent clocks at the end of each slot (articulation); 0 = legato
// PORTS
//  clk_i            in   1      system clock
//  rst_i            in   1      reset; synchronous, active-high
//  start_i          in   1      level/pulse; begins playback from note 0 when idle
//  stop_i           in   1      aborts playback; has priority over start_i
//  divider_value_i  in   BW     divider for note_index_o (combinational ROM, same cycle)
//  note_index_o     out  5      current note index into the ROM
//  tone_o           out  1      square-wave audio output
//  busy_o           out  1      high while in PLAY or GAP
//  note_strobe_o    out  1      one-cycle pulse in the first cycle of every note slot
//  done_o           out  1      one-cycle pulse when playback completes (non-loop build)
// BEHAVIOUR
//  Reset: state=IDLE; note_index_o=0; tone_o=0; busy_o=0; note_strobe_o=0; done_o=0.
//  Reset: tempo and tone counters=0. Reset mid-playback behaves identically.
//  FSM states: IDLE, PLAY, GAP. All outputs are registered.
//  IDLE: on start_i=1 and stop_i=0 at edge k, the cycle after is the first PLAY cycle.
//   - In that cycle: note_index_o=0, busy_o=1, note_strobe_o=1.
//  PLAY: lasts exactly TEMPO_CYCLES-GAP_CYCLES cycles.
//   - Then GAP if GAP_CYCLES>0; otherwise the next slot starts directly.
//  GAP: lasts exactly GAP_CYCLES cycles; tone_o=0 throughout.
//  Slot end with index<31: index+1, enter PLAY, note_strobe_o=1. Slot period = TEMPO_CYCLES exactly.
//  Slot end with index==31 (no loop): enter IDLE, index=0, busy_o=0.
//   - done_o=1 in the first IDLE cycle only.
//  Tone generator: tone_o=0 and tone counter=0 in each slot's first cycle.
//   - In PLAY with div=divider_value_i != 0: count 0..div-1.
//   - At count==div-1, toggle tone_o and clear the counter.
//   - Result: first rising edge div cycles after the slot start; half-period = div.
//   - div==0 (rest): tone_o held 0, counter held 0.
//   - div is sampled every cycle; the ROM is stable within a slot.
//  stop_i=1 in PLAY/GAP: next cycle IDLE, tone_o=0, index=0, busy_o=0, done_o=0.
//  stop_i=1 and start_i=1 together in IDLE: remain IDLE.
//  start_i while busy is ignored (no restart).
//  Tempo counter width: $clog2(TEMPO_CYCLES+1). Index wraps modulo 32 only via the loop option.
// CONFIGURATION
//  MELODY_LOOP_EN defined: at the end of slot 31, go to index 0 and PLAY.
//   - note_strobe_o=1, busy_o stays 1, done_o never asserts; only stop_i/rst_i end playback.
//  MELODY_LOOP_EN undefined: single pass; end-of-table behaviour as above, with a done_o pulse.
// TESTING
//  (bench params: TEMPO_CYCLES=8, GAP_CYCLES=2, behavioural ROM model; start at edge k)
//  1 Reset: rst_i high 3 cycles in PLAY -> all outputs 0, state IDLE next cycle.
//  2 Step timing: start_i pulse -> cycle k+1: idx=0, strobe=1, busy=1.
//     - idx=1 with strobe at k+9; idx=2 at k+17.
//  3 Tone: divider_value_i=3 -> tone_o rises at k+4, falls at k+7.
//     - tone_o=0 in GAP cycles k+7..k+8; reset at k+9.
//  4 Rest: divider_value_i=0 for idx 2 -> tone_o=0 for all 8 cycles of that slot.
//  5 Full pass: no macro -> done_o=1 and busy_o=0 at k+257, idx=0, single pulse.
//     - MELODY_LOOP_EN -> idx=0, strobe=1, busy=1 at k+257, done_o never asserts.
//  6 Abort: stop_i at idx=5 mid-PLAY -> next cycle busy=0, tone=0, idx=0.
//     - start_i and stop_i together in IDLE -> busy stays 0.

Source files
------------

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps a 32-entry note ROM at a fixed tempo and drives a square-wave tone.
// Build option: define MELODY_LOOP_EN to wrap from note 31 back to note 0 instead of stopping.
module melody_sequencer #(
    parameter int BW           = 16,
    parameter int TEMPO_CYCLES = 1500000,
    parameter int GAP_CYCLES   = 150000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic [BW-1:0] divider_value_i,
    output logic [4:0]    note_index_o,
    output logic          tone_o,
    output logic          busy_o,
    output logic          note_strobe_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int TW = $clog2(TEMPO_CYCLES + 1);

    // Last slot cycle spent sounding, and last cycle of the whole slot.
    localparam logic [TW-1:0] PLAY_LAST = TW'(TEMPO_CYCLES - GAP_CYCLES - 1);
    localparam logic [TW-1:0] SLOT_LAST = TW'(TEMPO_CYCLES - 1);
    localparam bit            LEGATO    = (GAP_CYCLES == 0);

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [BW-1:0] dcnt_q, dcnt_d;
    logic          tone_q, tone_d;
    logic          busy_q, busy_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;
    logic          slot_end;
    logic          last_note;
    logic          div_zero;
    logic          div_wrap;

    assign last_note = (idx_q == 5'd31);
    assign div_zero  = (divider_value_i == '0);
    assign div_wrap  = (dcnt_q == divider_value_i - BW'(1));

    // Next-state, slot timing and tone generation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tcnt_d   = tcnt_q + TW'(1);
        dcnt_d   = dcnt_q;
        tone_d   = tone_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        slot_end = 1'b0;

        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                dcnt_d = '0;
                tone_d = 1'b0;
                idx_d  = '0;
                if (start_i && !stop_i) begin
                    state_d  = PLAY;
                    strobe_d = 1'b1;
                end
            end
            PLAY: begin
                // Half-period counter; a zero divider is a rest.
                if (div_zero) begin
                    tone_d = 1'b0;
                    dcnt_d = '0;
                end else if (div_wrap) begin
                    tone_d = ~tone_q;
                    dcnt_d = '0;
                end else begin
                    dcnt_d = dcnt_q + BW'(1);
                end
                if (tcnt_q == PLAY_LAST) begin
                    if (LEGATO) begin
                        slot_end = 1'b1;
                    end else begin
                        state_d = GAP;
                        tone_d  = 1'b0;
                        dcnt_d  = '0;
                    end
                end
            end
            GAP: begin
                tone_d = 1'b0;
                dcnt_d = '0;
                if (tcnt_q == SLOT_LAST) begin
                    slot_end = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                tcnt_d  = '0;
                dcnt_d  = '0;
                tone_d  = 1'b0;
            end
        endcase

        // Every new slot starts silent with fresh counters.
        if (slot_end) begin
            tcnt_d = '0;
            dcnt_d = '0;
            tone_d = 1'b0;
            if (last_note) begin
`ifdef MELODY_LOOP_EN
                state_d  = PLAY;
                idx_d    = '0;
                strobe_d = 1'b1;
`else
                state_d  = IDLE;
                idx_d    = '0;
                done_d   = 1'b1;
`endif
            end else begin
                state_d  = PLAY;
                idx_d    = idx_q + 5'd1;
                strobe_d = 1'b1;
            end
        end

        // Abort wins over everything while playing.
        if (stop_i && (state_q != IDLE)) begin
            state_d  = IDLE;
            idx_d    = '0;
            tcnt_d   = '0;
            dcnt_d   = '0;
            tone_d   = 1'b0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tcnt_q   <= '0;
            dcnt_q   <= '0;
            tone_q   <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tcnt_q   <= tcnt_d;
            dcnt_q   <= dcnt_d;
            tone_q   <= tone_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign note_index_o  = idx_q;
    assign tone_o        = tone_q;
    assign busy_o        = busy_q;
    assign note_strobe_o = strobe_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed testbench for melody_sequencer with a behavioural note ROM.
// Short tempo (8-cycle slots, 2-cycle gap) keeps a full pass to 256 cycles.
module tb_melody_sequencer;

    localparam int BW    = 16;
    localparam int TEMPO = 8;
    localparam int GAP   = 2;
`ifdef MELODY_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [4:0] idx;
        logic       strobe;
        logic       busy;
        logic       tone;
        logic       done;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          stop_i;
    logic [BW-1:0] divider_value_i;
    logic [4:0]    note_index_o;
    logic          tone_o;
    logic          busy_o;
    logic          note_strobe_o;
    logic          done_o;

    logic [BW-1:0] rom [32];
    vec_t          vq [$];
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    int            done_cnt = 0;

    melody_sequencer #(
        .BW(BW),
        .TEMPO_CYCLES(TEMPO),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .start_i(start_i),
        .stop_i(stop_i),
        .divider_value_i(divider_value_i),
        .note_index_o(note_index_o),
        .tone_o(tone_o),
        .busy_o(busy_o),
        .note_strobe_o(note_strobe_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    assign divider_value_i = rom[note_index_o];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done_o) done_cnt++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] idx, input logic st,
                           input logic bs, input logic tn, input logic dn);
        chk({tag, " idx"}, 32'(note_index_o), 32'(idx));
        chk({tag, " strobe"}, 32'(note_strobe_o), 32'(st));
        chk({tag, " busy"}, 32'(busy_o), 32'(bs));
        chk({tag, " tone"}, 32'(tone_o), 32'(tn));
        chk({tag, " done"}, 32'(done_o), 32'(dn));
    endtask

    task automatic add(input int c, input logic [4:0] i, input logic s,
                       input logic b, input logic t, input logic d);
        vq.push_back('{c, i, s, b, t, d});
    endtask

    task automatic go_start();
        start_i = 1'b1;
        cyc = 0;
        done_cnt = 0;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = BW'((i % 4) + 1);
        rom[0] = 16'd3;
        rom[1] = 16'd2;
        rom[2] = 16'd0;

        // slot 0, div 3: rise at 4, fall lands in gap
        add(1, 5'd0, 1, 1, 0, 0);
        add(2, 5'd0, 0, 1, 0, 0);
        add(3, 5'd0, 0, 1, 0, 0);
        add(4, 5'd0, 0, 1, 1, 0);
        add(6, 5'd0, 0, 1, 1, 0);
        add(7, 5'd0, 0, 1, 0, 0);
        add(8, 5'd0, 0, 1, 0, 0);
        // slot 1, div 2
        add(9, 5'd1, 1, 1, 0, 0);
        add(10, 5'd1, 0, 1, 0, 0);
        add(11, 5'd1, 0, 1, 1, 0);
        add(12, 5'd1, 0, 1, 1, 0);
        add(13, 5'd1, 0, 1, 0, 0);
        add(15, 5'd1, 0, 1, 0, 0);
        // slot 2, rest
        add(17, 5'd2, 1, 1, 0, 0);
        add(18, 5'd2, 0, 1, 0, 0);
        add(19, 5'd2, 0, 1, 0, 0);
        add(20, 5'd2, 0, 1, 0, 0);
        add(21, 5'd2, 0, 1, 0, 0);
        add(22, 5'd2, 0, 1, 0, 0);
        add(23, 5'd2, 0, 1, 0, 0);
        add(24, 5'd2, 0, 1, 0, 0);
        add(25, 5'd3, 1, 1, 0, 0);
        // end of table
        add(249, 5'd31, 1, 1, 0, 0);
        add(256, 5'd31, 0, 1, 0, 0);
        add(257, 5'd0, LOOP, LOOP, 0, !LOOP);
        add(258, 5'd0, 0, LOOP, 0, 0);

        rst_i   = 1'b1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        repeat (3) tick();
        chk_all("reset", 5'd0, 0, 0, 0, 0);
        rst_i = 1'b0;
        tick();
        chk_all("idle", 5'd0, 0, 0, 0, 0);

        go_start();
        foreach (vq[n]) begin
            while (cyc < vq[n].cyc) tick();
            chk_all($sformatf("c%0d", vq[n].cyc), vq[n].idx, vq[n].strobe,
                    vq[n].busy, vq[n].tone, vq[n].done);
        end
        chk("done pulses", 32'(done_cnt), LOOP ? 32'd0 : 32'd1);

        // stop works from either playing or idle
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        chk("stop idle busy", 32'(busy_o), 32'd0);

        // abort mid-PLAY in slot 5 (div 2 -> tone high at cycle 43)
        go_start();
        while (cyc < 43) tick();
        chk_all("pre-abort", 5'd5, 0, 1, 1, 0);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        chk_all("abort", 5'd0, 0, 0, 0, 0);

        // start and stop together in idle
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        chk_all("start+stop", 5'd0, 0, 0, 0, 0);
        start_i = 1'b0;
        stop_i  = 1'b0;
        tick();
        chk("start+stop busy", 32'(busy_o), 32'd0);

        // start while busy is ignored
        go_start();
        while (cyc < 10) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk_all("restart ign", 5'd1, 0, 1, 1, 0);

        // reset while playing
        rst_i = 1'b1;
        tick();
        chk_all("rst play", 5'd0, 0, 0, 0, 0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk_all("post rst", 5'd0, 0, 0, 0, 0);
        go_start();
        chk_all("rst restart", 5'd0, 1, 1, 0, 0);
        while (cyc < 4) tick();
        chk("rst tone", 32'(tone_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
